// File: rtl/mdu_sequencer.sv
// Iterative RV32M multiply/divide sequencer: radix-2 shift-add multiply and
// restoring divide over one shared 2*XLEN accumulator, plus a fast path for
// the divide special cases.
module mdu_sequencer #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] rs1,
    input  logic [XLEN-1:0] rs2,
    input  logic            kill,
    output logic            stall,
    output logic            done,
    output logic [XLEN-1:0] result,
    output logic            busy
);

    localparam int CW = $clog2(XLEN + 1);
    localparam logic [XLEN-1:0] MIN_INT = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

    state_t            state;
    state_t            state_next;
    logic [2*XLEN-1:0] acc;
    logic [XLEN-1:0]   operand_b;
    logic [CW-1:0]     count;
    logic [2:0]        op;
    logic              neg;

    logic              a_signed;
    logic              b_signed;
    logic              a_neg;
    logic              b_neg;
    logic              sign_in;
    logic [XLEN-1:0]   a_abs;
    logic [XLEN-1:0]   b_abs;
    logic              div_by_zero;
    logic              overflow;
    logic              special;
    logic [XLEN-1:0]   special_value;
    logic [XLEN:0]     mul_sum;
    logic [2*XLEN-1:0] mul_next;
    logic [XLEN:0]     shifted_rem;
    logic [XLEN:0]     diff;
    logic [2*XLEN-1:0] div_next;
    logic [2*XLEN-1:0] prod_fixed;
    logic [XLEN-1:0]   div_val;
    logic [XLEN-1:0]   fix_value;

    // Operand conditioning, special-case detection and per-iteration datapath
    always_comb begin
        a_signed      = (funct3 == 3'b001) || (funct3 == 3'b010) ||
                        (funct3[2] && !funct3[0]);
        b_signed      = (funct3 == 3'b001) || (funct3[2] && !funct3[0]);
        a_neg         = a_signed && rs1[XLEN-1];
        b_neg         = b_signed && rs2[XLEN-1];
        a_abs         = a_neg ? -rs1 : rs1;
        b_abs         = b_neg ? -rs2 : rs2;
        sign_in       = (funct3[2] && funct3[1]) ? a_neg : (a_neg ^ b_neg);
        div_by_zero   = funct3[2] && (rs2 == '0);
        overflow      = funct3[2] && !funct3[0] && (rs1 == MIN_INT) && (rs2 == '1);
        special       = div_by_zero || overflow;
        special_value = '0;
        if (div_by_zero)
            special_value = funct3[1] ? rs1 : '1;
        else if (!funct3[1])
            special_value = MIN_INT;

        mul_sum     = {1'b0, acc[2*XLEN-1:XLEN]} + {1'b0, operand_b};
        mul_next    = acc[0] ? {mul_sum, acc[XLEN-1:1]} : {1'b0, acc[2*XLEN-1:1]};
        shifted_rem = acc[2*XLEN-1:XLEN-1];
        diff        = shifted_rem - {1'b0, operand_b};
        div_next    = diff[XLEN] ? {shifted_rem[XLEN-1:0], acc[XLEN-2:0], 1'b0}
                                 : {diff[XLEN-1:0], acc[XLEN-2:0], 1'b1};

        prod_fixed  = neg ? -acc : acc;
        div_val     = op[1] ? acc[2*XLEN-1:XLEN] : acc[XLEN-1:0];
        if (op[2])
            fix_value = neg ? -div_val : div_val;
        else if (op[1:0] == 2'b00)
            fix_value = prod_fixed[XLEN-1:0];
        else
            fix_value = prod_fixed[2*XLEN-1:XLEN];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_next;
    end

    // Next state and handshake outputs; kill always wins and suppresses done
    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (start) state_next = special ? DONE : CALC;
            CALC: if (count == CW'(1)) state_next = FIX;
            FIX:  state_next = DONE;
            DONE: state_next = IDLE;
            default: state_next = IDLE;
        endcase
        if (kill)
            state_next = IDLE;
        done  = (state == DONE) && !kill;
        stall = rst_n && start && !done && !kill;
        busy  = (state != IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc       <= '0;
            operand_b <= '0;
            count     <= '0;
            op        <= '0;
            neg       <= 1'b0;
            result    <= '0;
        end else if (!kill) begin
            case (state)
                IDLE: if (start) begin
                    op        <= funct3;
                    neg       <= sign_in;
                    operand_b <= b_abs;
                    acc       <= {{XLEN{1'b0}}, a_abs};
                    count     <= CW'(XLEN);
                    if (special)
                        result <= special_value;
                end
                CALC: begin
                    acc   <= op[2] ? div_next : mul_next;
                    count <= count - CW'(1);
                end
                FIX:     result <= fix_value;
                default: ;
            endcase
        end
    end

endmodule

// File: doc/mdu_sequencer.md
Name: mdu_sequencer

Overview:
- Iterative multiply/divide unit and sequencer for the RV32M instructions (opcode 0110011, funct7=0000001).
- Sits beside the ALU in the single-cycle core.
- The core raises start when decode sees an M-instruction. The block stalls the PC/register-file write until the result is ready, then presents it for one commit cycle.
- Uses a radix-2 shift-add multiplier and a restoring divider sharing one accumulator/shift datapath, with a one-cycle fast path for the architectural special cases.

Parameters:
- XLEN, 32, operand/result width; iteration count equals XLEN.

Ports:
- clk  input  1  core clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  M-instruction in decode; held high by the core for as long as stall=1.
- funct3  input  3  operation: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- rs1  input  XLEN  operand a; sampled only in the IDLE capture cycle.
- rs2  input  XLEN  operand b; sampled only in the IDLE capture cycle.
- kill  input  1  trap/flush; aborts any operation in progress.
- stall  output  1  freeze PC and suppress register write; combinational.
- done  output  1  result valid this cycle; the core commits rd.
- result  output  XLEN  registered result.
- busy  output  1  state is not IDLE.

Behaviour:
- Reset (rst_n=0, asynchronous):
  - State goes to IDLE.
  - result, the accumulator, the counter and the sign flags are cleared to 0.
  - done=0, busy=0, stall=0.
  - Reset asserted mid-operation discards the operation; no done pulse follows.
- States: IDLE, CALC, FIX, DONE.
- IDLE:
  - If start=1 and kill=0, capture funct3 and the operands.
  - Signed ops (MULH, MULHSU for a only, DIV, REM) take the absolute value of each signed operand and record the result sign:
    - Products: sign(a) XOR sign(b).
    - Quotient: sign(a) XOR sign(b).
    - Remainder: sign(a).
  - Special case, divide by zero (rs2=0): quotient = all ones; remainder = rs1. Result is loaded now; go to DONE.
  - Special case, signed overflow (DIV/REM with rs1=0x80000000, rs2=0xFFFFFFFF): quotient = 0x80000000; remainder = 0. Go to DONE.
  - Otherwise load counter=XLEN and go to CALC.
- CALC: one iteration per cycle; counter decrements; go to FIX when the counter reaches 1.
  - Multiply: if the product LSB-side multiplier bit is 1, add the multiplicand into the upper half of the 2*XLEN accumulator; then shift right 1 with carry.
  - Divide (restoring): shift {rem,quot} left 1; trial-subtract the divisor from rem; if non-negative, keep the difference and set quot LSB=1.
- FIX (one cycle):
  - Apply two's-complement negation when the sign flag is set: the 2*XLEN product for multiplies, the XLEN quotient or remainder for divides.
  - Select the output: MUL takes the low word; MULH/MULHSU/MULHU take the high word.
  - Register into result; go to DONE.
- DONE: done=1 for exactly one cycle; go to IDLE unconditionally. The core advances the PC at the end of this cycle.
- stall = start AND NOT done AND NOT kill. It is 1 in the IDLE capture cycle and throughout CALC/FIX.
- Latency from the capture cycle to the done cycle:
  - Normal: XLEN+2 cycles (done at cycle 34 for XLEN=32).
  - Special case: 1 cycle (done at cycle 1).
- Back-to-back ops: after DONE, IDLE re-samples start next cycle. An M-instruction that immediately follows starts without a bubble beyond the IDLE capture cycle.
- kill=1 in any state:
  - Next state is IDLE; done is forced to 0 that cycle; stall=0.
  - result keeps its previous value.
  - kill has priority over start in IDLE.
- Operands and funct3 changing during CALC/FIX have no effect.
- done and result change only on clock edges. result holds its value until the next FIX or special-case load.

Test Plan:
- MUL rs1=7, rs2=0xFFFFFFFD (-3), start held -> stall=1 for cycles 0..33; done=1 and result=0xFFFFFFEB at cycle 34; busy=0 at cycle 35.
- MULHU rs1=rs2=0xFFFFFFFF -> result 0xFFFFFFFE. MULH with the same operands -> 0x00000000. MULHSU rs1=0xFFFFFFFF, rs2=2 -> 0xFFFFFFFF.
- DIV rs1=0xFFFFFFF9 (-7), rs2=2 -> 0xFFFFFFFD. REM with the same operands -> 0xFFFFFFFF. DIVU 100/7 -> 14. REMU 100/7 -> 2.
- DIVU rs2=0 -> result 0xFFFFFFFF with done at cycle 1. REM rs1=0x80000000, rs2=0xFFFFFFFF -> result 0 with done at cycle 1. DIV with the same operands -> 0x80000000.
- kill pulsed at cycle 10 of a MUL -> IDLE at cycle 11, no done pulse, result unchanged. A new DIVU 9/3 started at cycle 12 -> result 3 at cycle 46.
- rst_n dropped asynchronously at cycle 5 of a DIV -> busy, stall and done go to 0 immediately and result=0. After release, a MUL 3*4 completes with result 12.
